// File: rtl/unibus_pkg.sv
// Shared types and default configuration for the UNIBUS BR/NPR arbiter.
package unibus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_GRANT  = 2'd2,
    ST_SACKED = 2'd3
  } arb_state_e;

  localparam int DEF_NBR       = 4;
  localparam int DEF_BASE_PL   = 4;
  localparam int DEF_SACK_FILT = 2;
  localparam int DEF_SACK_TO   = 200;

endpackage : unibus_pkg

// File: rtl/br_prio_enc.sv
// Highest-level eligible BR selector: a level wins only if it is above the
// processor priority; the result is one-hot plus the winning level number.
module br_prio_enc
  import unibus_pkg::*;
#(
  parameter int NBR     = DEF_NBR,
  parameter int BASE_PL = DEF_BASE_PL
) (
  input  logic [NBR-1:0] req_i,
  input  logic [2:0]     ps_pl_i,
  output logic [NBR-1:0] onehot_o,
  output logic [2:0]     level_o,
  output logic           any_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    onehot_o = '0;
    level_o  = '0;
    any_o    = 1'b0;
    // Ascending scan: the last eligible hit is the highest level.
    for (int i = 0; i < NBR; i++) begin
      if (req_i[i] && ((BASE_PL + i) > int'(ps_pl_i))) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        level_o     = 3'(BASE_PL + i);
        any_o       = 1'b1;
      end
    end
  end

endmodule : br_prio_enc

// File: rtl/unibus_arb.sv
// UNIBUS bus arbiter: samples BR/NPR requests, issues one grant at a time,
// waits for a filtered SACK (or times out), then for the bus to go idle.
module unibus_arb
  import unibus_pkg::*;
#(
  parameter int NBR       = DEF_NBR,
  parameter int BASE_PL   = DEF_BASE_PL,
  parameter int SACK_FILT = DEF_SACK_FILT,
  parameter int SACK_TO   = DEF_SACK_TO
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     ps_pl,
  input  logic           arb_req,
  input  logic           npr_en,
  input  logic [NBR-1:0] bus_br,
  input  logic           bus_npr,
  input  logic           bus_sack,
  input  logic           bus_bbsy,
  input  logic           bus_init,
  input  logic           bus_pwr_lo,
  output logic [NBR-1:0] bus_bg,
  output logic           bus_npg,
  output logic           brq,
  output logic [2:0]     grant_pl,
  output logic           nosack,
  output logic           busy
);

  localparam int CW = $clog2(SACK_TO + 1);
  localparam int FW = $clog2(SACK_FILT + 1);

  arb_state_e     state_q;
  logic [NBR-1:0] br_lat_q;
  logic           npr_lat_q;
  logic           arb_lat_q;
  logic [CW-1:0]  to_cnt_q;
  logic [FW-1:0]  sack_cnt_q;
  logic [NBR-1:0] bg_q;
  logic           npg_q;
  logic [2:0]     grant_pl_q;
  logic           nosack_q;

  logic [NBR-1:0] lat_onehot;
  logic [2:0]     lat_level;
  logic           lat_any;
  logic [NBR-1:0] live_onehot;
  logic [2:0]     live_level;
  logic           live_any;

  logic           npr_go;
  logic [CW-1:0]  to_cnt_inc;
  logic           timeout;
  logic [FW-1:0]  sack_cnt_inc;
  logic           sack_ok;

  // Latched requests decide the grant; live requests only drive brq.
  br_prio_enc #(.NBR(NBR), .BASE_PL(BASE_PL)) u_enc_lat (
    .req_i    (br_lat_q),
    .ps_pl_i  (ps_pl),
    .onehot_o (lat_onehot),
    .level_o  (lat_level),
    .any_o    (lat_any)
  );

  br_prio_enc #(.NBR(NBR), .BASE_PL(BASE_PL)) u_enc_live (
    .req_i    (bus_br),
    .ps_pl_i  (ps_pl),
    .onehot_o (live_onehot),
    .level_o  (live_level),
    .any_o    (live_any)
  );

  assign npr_go       = bus_npr & npr_en & ~bus_pwr_lo;
  assign to_cnt_inc   = (to_cnt_q == CW'(SACK_TO)) ? to_cnt_q : to_cnt_q + 1'b1;
  assign timeout      = (to_cnt_inc == CW'(SACK_TO));
  assign sack_cnt_inc = (sack_cnt_q == FW'(SACK_FILT)) ? sack_cnt_q : sack_cnt_q + 1'b1;
  // SACK counts as asserted on the SACK_FILT-th consecutive high sample.
  assign sack_ok      = bus_sack && (sack_cnt_q >= FW'(SACK_FILT - 1));

  // NOTE: all state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || bus_init) begin
      state_q    <= ST_IDLE;
      br_lat_q   <= '0;
      npr_lat_q  <= 1'b0;
      arb_lat_q  <= 1'b0;
      to_cnt_q   <= '0;
      sack_cnt_q <= '0;
      bg_q       <= '0;
      npg_q      <= 1'b0;
      nosack_q   <= 1'b0;
      if (reset) grant_pl_q <= '0;
    end else begin
      nosack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_req || npr_go) begin
            br_lat_q  <= bus_br;
            npr_lat_q <= npr_go;
            arb_lat_q <= arb_req;
            state_q   <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          to_cnt_q   <= '0;
          sack_cnt_q <= '0;
          br_lat_q   <= '0;
          npr_lat_q  <= 1'b0;
          arb_lat_q  <= 1'b0;
          if (npr_lat_q) begin
            npg_q   <= 1'b1;
            state_q <= ST_GRANT;
          end else if (arb_lat_q && lat_any) begin
            bg_q       <= lat_onehot;
            grant_pl_q <= lat_level;
            state_q    <= ST_GRANT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          to_cnt_q   <= to_cnt_inc;
          sack_cnt_q <= bus_sack ? sack_cnt_inc : '0;
          if (sack_ok) begin
            bg_q    <= '0;
            npg_q   <= 1'b0;
            state_q <= ST_SACKED;
          end else if (timeout) begin
            bg_q     <= '0;
            npg_q    <= 1'b0;
            nosack_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_SACKED: begin
          sack_cnt_q <= '0;
          if (!bus_sack && !bus_bbsy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_bg   = bg_q;
  assign bus_npg  = npg_q;
  assign grant_pl = grant_pl_q;
  assign nosack   = nosack_q;
  assign busy     = (state_q != ST_IDLE);
  assign brq      = live_any;

endmodule : unibus_arb

// File: tb/tb_unibus_arb.sv
// Directed-vector bench for unibus_arb with hand-computed expectations.
module tb_unibus_arb;

  localparam int NBR       = 4;
  localparam int BASE_PL   = 4;
  localparam int SACK_FILT = 2;
  localparam int SACK_TO   = 200;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     ps_pl;
  logic           arb_req;
  logic           npr_en;
  logic [NBR-1:0] bus_br;
  logic           bus_npr, bus_sack, bus_bbsy, bus_init, bus_pwr_lo;
  logic [NBR-1:0] bus_bg;
  logic           bus_npg, brq, nosack, busy;
  logic [2:0]     grant_pl;

  int n_vec = 0;
  int n_err = 0;

  unibus_arb #(
    .NBR(NBR), .BASE_PL(BASE_PL), .SACK_FILT(SACK_FILT), .SACK_TO(SACK_TO)
  ) dut (
    .clk(clk), .reset(reset), .ps_pl(ps_pl), .arb_req(arb_req), .npr_en(npr_en),
    .bus_br(bus_br), .bus_npr(bus_npr), .bus_sack(bus_sack), .bus_bbsy(bus_bbsy),
    .bus_init(bus_init), .bus_pwr_lo(bus_pwr_lo), .bus_bg(bus_bg), .bus_npg(bus_npg),
    .brq(brq), .grant_pl(grant_pl), .nosack(nosack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs driven afterwards are stable
  // for the next edge and outputs read here reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ps_pl = 3'd0; arb_req = 1'b0; npr_en = 1'b0; bus_br = '0;
    bus_npr = 1'b0; bus_sack = 1'b0; bus_bbsy = 1'b0; bus_init = 1'b0; bus_pwr_lo = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    n_vec++; if (bus_bg !== 4'b0000) begin n_err++; $display("FAIL reset_bg: got %b want 0000", bus_bg); end
    n_vec++; if (bus_npg !== 1'b0) begin n_err++; $display("FAIL reset_npg: got %b want 0", bus_npg); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (nosack !== 1'b0) begin n_err++; $display("FAIL reset_nosack: got %b want 0", nosack); end
    n_vec++; if (grant_pl !== 3'd0) begin n_err++; $display("FAIL reset_grant_pl: got %0d want 0", grant_pl); end
  endtask

  task automatic test_br_grant_and_filter();
    ps_pl = 3'd4; bus_br = 4'b0110; arb_req = 1'b1;
    #1;
    n_vec++; if (brq !== 1'b1) begin n_err++; $display("FAIL br_brq: got %b want 1", brq); end
    step();
    arb_req = 1'b0;
    n_vec++; if (busy !== 1'b1 || bus_bg !== 4'b0000) begin n_err++; $display("FAIL br_sample: busy %b bg %b want busy 1 bg 0000", busy, bus_bg); end
    step();
    n_vec++; if (bus_bg !== 4'b0100) begin n_err++; $display("FAIL br_grant_bg: got %b want 0100", bus_bg); end
    n_vec++; if (grant_pl !== 3'd6) begin n_err++; $display("FAIL br_grant_pl: got %0d want 6", grant_pl); end
    bus_br = '0;
    // One-clock SACK glitch must not release the grant.
    bus_sack = 1'b1; bus_bbsy = 1'b1;
    step();
    bus_sack = 1'b0;
    n_vec++; if (bus_bg !== 4'b0100) begin n_err++; $display("FAIL glitch_hold1: got %b want 0100", bus_bg); end
    step();
    n_vec++; if (bus_bg !== 4'b0100) begin n_err++; $display("FAIL glitch_hold2: got %b want 0100", bus_bg); end
    bus_sack = 1'b1;
    step();
    n_vec++; if (bus_bg !== 4'b0100) begin n_err++; $display("FAIL sack_first: got %b want 0100", bus_bg); end
    step();
    n_vec++; if (bus_bg !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL sacked: bg %b busy %b want 0000 1", bus_bg, busy); end
    bus_sack = 1'b0;
    step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sacked_bbsy_hold: got %b want 1", busy); end
    bus_bbsy = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sacked_exit: got %b want 0", busy); end
  endtask

  task automatic test_no_eligible();
    ps_pl = 3'd7; bus_br = 4'b1111; arb_req = 1'b1;
    #1;
    n_vec++; if (brq !== 1'b0) begin n_err++; $display("FAIL noelig_brq: got %b want 0", brq); end
    step();
    arb_req = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL noelig_sample: got %b want 1", busy); end
    step();
    n_vec++; if (busy !== 1'b0 || bus_bg !== 4'b0000) begin n_err++; $display("FAIL noelig_idle: busy %b bg %b want 0 0000", busy, bus_bg); end
    bus_br = '0;
  endtask

  task automatic test_npr_wins();
    ps_pl = 3'd4; bus_br = 4'b1000; bus_npr = 1'b1; npr_en = 1'b1; arb_req = 1'b1;
    step();
    arb_req = 1'b0;
    step();
    n_vec++; if (bus_npg !== 1'b1 || bus_bg !== 4'b0000) begin n_err++; $display("FAIL npr_wins: npg %b bg %b want 1 0000", bus_npg, bus_bg); end
    n_vec++; if (grant_pl !== 3'd6) begin n_err++; $display("FAIL npr_grant_pl_hold: got %0d want 6", grant_pl); end
    bus_br = '0; bus_sack = 1'b1;
    step(); step();
    n_vec++; if (bus_npg !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL npr_sacked: npg %b busy %b want 0 1", bus_npg, busy); end
    bus_sack = 1'b0; bus_npr = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL npr_idle: got %b want 0", busy); end
  endtask

  task automatic test_npr_gating();
    bus_npr = 1'b1; npr_en = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL npr_en_low: busy %b want 0", busy); end
    npr_en = 1'b1; bus_pwr_lo = 1'b1;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL npr_pwr_lo: busy %b want 0", busy); end
    bus_pwr_lo = 1'b0;
    step();
    bus_npr = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL npr_only_sample: busy %b want 1", busy); end
    step();
    n_vec++; if (bus_npg !== 1'b1) begin n_err++; $display("FAIL npr_only_grant: npg %b want 1", bus_npg); end
    bus_init = 1'b1;
    step();
    bus_init = 1'b0;
    n_vec++; if (bus_npg !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL npr_init_clear: npg %b busy %b want 0 0", bus_npg, busy); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    ps_pl = 3'd4; bus_br = 4'b0010; arb_req = 1'b1;
    step();
    arb_req = 1'b0; bus_br = '0;
    step();
    n_vec++; if (bus_bg !== 4'b0010 || grant_pl !== 3'd5) begin n_err++; $display("FAIL to_grant: bg %b pl %0d want 0010 5", bus_bg, grant_pl); end
    for (int k = 1; k < SACK_TO; k++) begin
      step();
      if (nosack !== 1'b0 || bus_bg !== 4'b0010) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL to_early: %0d bad cycles want 0", early); end
    step();
    n_vec++; if (nosack !== 1'b1 || bus_bg !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL to_pulse: nosack %b bg %b busy %b want 1 0000 0", nosack, bus_bg, busy); end
    step();
    n_vec++; if (nosack !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b want 0", nosack); end
  endtask

  task automatic test_init_in_grant();
    ps_pl = 3'd0; bus_br = 4'b1000; arb_req = 1'b1;
    step();
    arb_req = 1'b0;
    step();
    n_vec++; if (bus_bg !== 4'b1000 || grant_pl !== 3'd7) begin n_err++; $display("FAIL init_pre: bg %b pl %0d want 1000 7", bus_bg, grant_pl); end
    bus_init = 1'b1; bus_sack = 1'b1; arb_req = 1'b1;
    step();
    bus_init = 1'b0; bus_sack = 1'b0; arb_req = 1'b0; bus_br = '0;
    n_vec++; if (bus_bg !== 4'b0000 || busy !== 1'b0 || nosack !== 1'b0) begin n_err++; $display("FAIL init_clear: bg %b busy %b nosack %b want 0000 0 0", bus_bg, busy, nosack); end
    step();
    n_vec++; if (busy !== 1'b0 || nosack !== 1'b0) begin n_err++; $display("FAIL init_stay_idle: busy %b nosack %b want 0 0", busy, nosack); end
  endtask

  task automatic test_reset_mid_grant();
    ps_pl = 3'd4; bus_br = 4'b0100; arb_req = 1'b1;
    step();
    arb_req = 1'b0;
    step();
    n_vec++; if (bus_bg !== 4'b0100) begin n_err++; $display("FAIL rst_pre: bg %b want 0100", bus_bg); end
    reset = 1'b1;
    step();
    reset = 1'b0; bus_br = '0;
    n_vec++; if (bus_bg !== 4'b0000 || nosack !== 1'b0 || busy !== 1'b0 || grant_pl !== 3'd0) begin
      n_err++; $display("FAIL rst_mid: bg %b nosack %b busy %b pl %0d want 0000 0 0 0", bus_bg, nosack, busy, grant_pl);
    end
  endtask

  initial begin
    test_reset();
    test_br_grant_and_filter();
    test_no_eligible();
    test_npr_wins();
    test_npr_gating();
    test_timeout();
    test_init_in_grant();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_unibus_arb
